src_hazard_tracker: RTL and testbench
=====================================

# src_hazard_tracker

Parametrised operand-source decoder and in-flight destination scoreboard for the pipelined MIPS core, sitting at the D stage alongside the register file. It decodes the A/B source registers of the instruction in D, tracks the destinations of the DEPTH instructions downstream of D, and produces a load-use stall request and per-operand forwarding selects. A saturating stall counter supports performance checks.

## Interface
- DEPTH, 3: tracked stages after D (entry 0 = E, 1 = M, 2 = W).
- ALU_RDY, 0: lowest entry index from which a non-load result may be forwarded.
- LOAD_RDY, 1: lowest entry index from which a load result may be forwarded; LOAD_RDY >= ALU_RDY, both < DEPTH.
- CNT_W, 16: stall counter width.
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- D_op  input  6  opcode of instruction in D; uses the shared opcode macros.
- D_rs, D_rt  input  5  rs/rt fields of instruction in D.
- D_valid  input  1  D holds a real instruction.
- D_wen, D_isload  input  1  D instruction writes D_dst / is a load.
- D_dst  input  5  destination register of D instruction.
- E_flush  input  1  instruction in D is killed (branch resolved in E).
- d_srcA, d_srcB  output  5  decoded source registers (0 = none).
- stall  output  1  hold D and F; insert bubble into E.
- fwdA, fwdB  output  clog2(DEPTH+1)  0 = register file, k = entry k-1.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

## Operation
- Source decode (combinational): `IROP, `ISW, `IBEQ, `IBNE: srcA = D_rs, srcB = D_rt. `IJ, `IJAL: both 0. All other opcodes: srcA = D_rs, srcB = 0. D_valid = 0 forces both to 0.
- Scoreboard: DEPTH entries {v, dst, ld}, entry 0 youngest.
- Per source s: if s == 0, fwd = 0 and no hazard. Otherwise find the lowest index k with v[k] && dst[k] == s (youngest producer wins).
  - No match: fwd = 0.
  - Match, rdy = ld[k] ? LOAD_RDY : ALU_RDY: if k >= rdy, fwd = k+1; else hazard.
- stall = (hazardA | hazardB) & ~E_flush. While stall = 1, fwdA/fwdB are don't-care; the bench checks them only when stall = 0.
- Update per cycle:
  - entry[i] <= entry[i-1] for i >= 1.
  - entry[0] <= {D_valid & D_wen & (D_dst != 0) & ~stall & ~E_flush, D_dst, D_isload}.
  - stall and flush therefore both insert a bubble.
- stall_cnt increments on each cycle with stall = 1 and holds at 2^CNT_W - 1.

## Timing
- Outputs d_src*, fwd*, stall: combinational from D inputs and registered entries, valid in the same cycle.
- Scoreboard shift and counter update: one cycle latency, on the rising clk edge.
- Reset (rst_n = 0 at an edge): all v cleared and stall_cnt = 0, regardless of other inputs.
  - Outputs after reset: stall = 0, fwdA = fwdB = 0; d_srcA/d_srcB follow decode.
  - Reset mid-stall discards all tracked producers; the next cycle shows no hazard.
- E_flush with a hazard present: stall = 0, counter unchanged, bubble into entry 0.
- Destination 0 is never tracked.
- A producer leaving entry DEPTH-1 is assumed committed to the register file and falls back to fwd = 0.
- Same register in srcA and srcB: both selects are identical.

## Test plan
Defaults unless noted.
- **Reset:** rst_n = 0 for 2 cycles with D_valid = 1 and lw traffic, then release -> stall = 0, fwdA = fwdB = 0, stall_cnt = 0.
- **ALU chain:** add $8 then add $9,$8,$8 in consecutive cycles -> second in D: stall = 0, fwdA = fwdB = 1; one cycle later (if held in D): 2.
- **Load-use:** lw $8 then sub $9,$8,$3 -> cycle 2: stall = 1, stall_cnt 0->1; cycle 3: stall = 0, fwdA = 2, fwdB = 0.
- **Youngest wins:** add $5; lw $5; or $6,$5,$0 back-to-back -> stall = 1 (load at entry 0), then fwdA = 2 (the load, not the add at entry 2).
- **Decode / $0:** `IJ with rs = 19 -> d_srcA = d_srcB = 0. `ISW rs = 16, rt = 18 -> d_srcA = 16, d_srcB = 18. Producer writing $0 -> never a hazard.
- **Flush/saturation, CNT_W = 3:**
  - lw $8 then a dependent instruction with E_flush = 1 -> stall = 0, counter unchanged.
  - Hold a hazard 10 cycles (DEPTH = 4, LOAD_RDY = 3, re-issue producer) -> stall_cnt stops at 7.

Source files
------------

// File: rtl/src_hazard_tracker.sv
// Operand-source decode plus in-flight destination scoreboard: load-use stall and per-operand forward selects.
// Decode/stall/forward are combinational in D; scoreboard shift and stall counter update on the next clk edge; stall holds D/F.

`ifndef IROP
`define IROP 6'b000000
`endif
`ifndef IJ
`define IJ   6'b000010
`endif
`ifndef IJAL
`define IJAL 6'b000011
`endif
`ifndef IBEQ
`define IBEQ 6'b000100
`endif
`ifndef IBNE
`define IBNE 6'b000101
`endif
`ifndef ISW
`define ISW  6'b101011
`endif

module src_hazard_tracker #(
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1,
    parameter int CNT_W    = 16,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       D_op,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic             D_valid,
    input  logic             D_wen,
    input  logic             D_isload,
    input  logic [4:0]       D_dst,
    input  logic             E_flush,
    output logic [4:0]       d_srcA,
    output logic [4:0]       d_srcB,
    output logic             stall,
    output logic [FW-1:0]    fwdA,
    output logic [FW-1:0]    fwdB,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       ld;
    } entry_t;

    typedef struct packed {
        logic          haz;
        logic [FW-1:0] fwd;
    } sel_t;

    entry_t [DEPTH-1:0] sb;
    sel_t               sel_a;
    sel_t               sel_b;

    // Scan oldest to youngest so the youngest matching producer is the one kept.
    function automatic sel_t resolve(input logic [4:0] src, input entry_t [DEPTH-1:0] tab);
        sel_t r;
        int   k;
        logic ld_hit;
        r      = '0;
        k      = -1;
        ld_hit = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tab[i].v && tab[i].dst == src) begin
                k      = i;
                ld_hit = tab[i].ld;
            end
        end
        if (src != 5'd0 && k >= 0) begin
            if (k >= (ld_hit ? LOAD_RDY : ALU_RDY))
                r.fwd = FW'(k + 1);
            else
                r.haz = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        d_srcA = 5'd0;
        d_srcB = 5'd0;
        if (D_valid) begin
            case (D_op)
                `IROP, `ISW, `IBEQ, `IBNE: begin
                    d_srcA = D_rs;
                    d_srcB = D_rt;
                end
                `IJ, `IJAL: begin
                    d_srcA = 5'd0;
                    d_srcB = 5'd0;
                end
                default: d_srcA = D_rs;
            endcase
        end
    end

    always_comb begin
        sel_a = resolve(d_srcA, sb);
        sel_b = resolve(d_srcB, sb);
        stall = (sel_a.haz | sel_b.haz) & ~E_flush;
        fwdA  = sel_a.fwd;
        fwdB  = sel_b.fwd;
    end

    // A stalled or flushed D instruction enters E as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb        <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++)
                sb[i] <= sb[i-1];
            sb[0] <= '{v:   D_valid & D_wen & (D_dst != 5'd0) & ~stall & ~E_flush,
                       dst: D_dst,
                       ld:  D_isload};
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_src_hazard_tracker.sv
// Randomised plus directed stimulus against an age-based producer-history model, for two parameter sets.

module tb_src_hazard_tracker;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam int NLOG = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, D_valid, D_wen, D_isload, E_flush;
    logic [5:0] D_op;
    logic [4:0] D_rs, D_rt, D_dst;

    logic [4:0]  srcA0, srcB0, srcA1, srcB1;
    logic        stall0, stall1;
    logic [1:0]  fwdA0, fwdB0;
    logic [2:0]  fwdA1, fwdB1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;

    src_hazard_tracker u_dut0 (
        .clk(clk), .rst_n(rst_n), .D_op(D_op), .D_rs(D_rs), .D_rt(D_rt),
        .D_valid(D_valid), .D_wen(D_wen), .D_isload(D_isload), .D_dst(D_dst),
        .E_flush(E_flush), .d_srcA(srcA0), .d_srcB(srcB0), .stall(stall0),
        .fwdA(fwdA0), .fwdB(fwdB0), .stall_cnt(cnt0)
    );

    src_hazard_tracker #(.DEPTH(4), .ALU_RDY(0), .LOAD_RDY(3), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .D_op(D_op), .D_rs(D_rs), .D_rt(D_rt),
        .D_valid(D_valid), .D_wen(D_wen), .D_isload(D_isload), .D_dst(D_dst),
        .E_flush(E_flush), .d_srcA(srcA1), .d_srcB(srcB1), .stall(stall1),
        .fwdA(fwdA1), .fwdB(fwdB1), .stall_cnt(cnt1)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // History of what each design accepted into E, indexed by the cycle it was in D.
    logic       lv  [2][NLOG];
    logic [4:0] ldst[2][NLOG];
    logic       lld [2][NLOG];
    int last_rst[2] = '{-1, -1};
    int mcnt[2]     = '{0, 0};
    int m_depth[2]  = '{3, 4};
    int m_lrdy[2]   = '{1, 3};
    int m_max[2]    = '{65535, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void ref_decode(output logic [4:0] a, output logic [4:0] b);
        a = 5'd0;
        b = 5'd0;
        if (D_valid) begin
            if (D_op == OP_R || D_op == OP_SW || D_op == OP_BEQ || D_op == OP_BNE) begin
                a = D_rs;
                b = D_rt;
            end else if (D_op != OP_J && D_op != OP_JAL) begin
                a = D_rs;
            end
        end
    endfunction

    // Producer in stage k right now is the instruction that sat in D k+1 cycles ago.
    function automatic void ref_lookup(input int d, input logic [4:0] s,
                                       output logic haz, output int fwd);
        int c;
        haz = 1'b0;
        fwd = 0;
        if (s == 5'd0) return;
        for (int k = 0; k < m_depth[d]; k++) begin
            c = cyc - 1 - k;
            if (c < 0 || c <= last_rst[d]) return;
            if (lv[d][c] && ldst[d][c] == s) begin
                if (k >= (lld[d][c] ? m_lrdy[d] : 0)) fwd = k + 1;
                else haz = 1'b1;
                return;
            end
        end
    endfunction

    task automatic run_cycle();
        logic [4:0] ea, eb;
        logic       ha, hb, es;
        int         fa, fb;
        logic [4:0] ga, gb;
        logic       gs;
        logic [31:0] gfa, gfb, gc;
        @(negedge clk);
        ref_decode(ea, eb);
        for (int d = 0; d < 2; d++) begin
            ref_lookup(d, ea, ha, fa);
            ref_lookup(d, eb, hb, fb);
            es = (ha | hb) & ~E_flush;
            if (d == 0) begin
                ga = srcA0; gb = srcB0; gs = stall0;
                gfa = 32'(fwdA0); gfb = 32'(fwdB0); gc = 32'(cnt0);
            end else begin
                ga = srcA1; gb = srcB1; gs = stall1;
                gfa = 32'(fwdA1); gfb = 32'(fwdB1); gc = 32'(cnt1);
            end
            if (cyc > 0) begin
                check($sformatf("srcA%0d", d), 32'(ga), 32'(ea));
                check($sformatf("srcB%0d", d), 32'(gb), 32'(eb));
                check($sformatf("stall%0d", d), 32'(gs), 32'(es));
                check($sformatf("cnt%0d", d), gc, 32'(mcnt[d]));
                if (!es) begin
                    check($sformatf("fwdA%0d", d), gfa, 32'(fa));
                    check($sformatf("fwdB%0d", d), gfb, 32'(fb));
                end
            end
            lv[d][cyc]   = rst_n & D_valid & D_wen & (D_dst != 5'd0) & ~es & ~E_flush;
            ldst[d][cyc] = D_dst;
            lld[d][cyc]  = D_isload;
            if (!rst_n) begin
                last_rst[d] = cyc;
                mcnt[d]     = 0;
            end else if (es) begin
                mcnt[d] = (mcnt[d] + 1 > m_max[d]) ? m_max[d] : mcnt[d] + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [5:0] op, input int rs, input int rt, input int dst,
                         input logic flush, input logic rst);
        rst_n    = ~rst;
        D_valid  = 1'b1;
        D_op     = op;
        D_rs     = 5'(rs);
        D_rt     = 5'(rt);
        D_dst    = 5'(dst);
        D_wen    = (op == OP_R || op == OP_LW || op == OP_ADDI || op == OP_ORI || op == OP_JAL);
        D_isload = (op == OP_LW);
        E_flush  = flush;
        run_cycle();
    endtask

    logic [5:0] ops[9] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW};

    initial begin
        rst_n = 1'b0; D_valid = 1'b0; D_wen = 1'b0; D_isload = 1'b0; E_flush = 1'b0;
        D_op = '0; D_rs = '0; D_rt = '0; D_dst = '0;
        #1;
        // Reset with load traffic in D
        issue(OP_LW, 0, 0, 8, 1'b0, 1'b1);
        issue(OP_LW, 0, 0, 8, 1'b0, 1'b1);
        issue(OP_R, 1, 2, 3, 1'b0, 1'b0);
        // ALU chain, dependent held two cycles
        issue(OP_R, 1, 2, 8, 1'b0, 1'b0);
        issue(OP_R, 8, 8, 9, 1'b0, 1'b0);
        issue(OP_R, 8, 8, 9, 1'b0, 1'b0);
        // Load-use
        issue(OP_LW, 0, 0, 8, 1'b0, 1'b0);
        repeat (3) issue(OP_R, 8, 3, 9, 1'b0, 1'b0);
        // Youngest producer wins
        issue(OP_R, 1, 2, 5, 1'b0, 1'b0);
        issue(OP_LW, 0, 0, 5, 1'b0, 1'b0);
        repeat (3) issue(OP_R, 5, 0, 6, 1'b0, 1'b0);
        // Decode and $0 destination
        issue(OP_J, 19, 0, 0, 1'b0, 1'b0);
        issue(OP_SW, 16, 18, 0, 1'b0, 1'b0);
        issue(OP_LW, 0, 0, 0, 1'b0, 1'b0);
        issue(OP_R, 0, 0, 7, 1'b0, 1'b0);
        // Flush over a load-use hazard
        issue(OP_LW, 0, 0, 8, 1'b0, 1'b0);
        issue(OP_R, 8, 3, 9, 1'b1, 1'b0);
        issue(OP_R, 8, 3, 9, 1'b0, 1'b0);
        // Repeated load-use pairs drive the 3-bit counter into saturation
        repeat (10) begin
            issue(OP_LW, 0, 0, 8, 1'b0, 1'b0);
            issue(OP_R, 8, 3, 9, 1'b0, 1'b0);
        end
        check("sat_cnt", 32'(cnt1), 32'd7);
        // Reset mid-stall discards producers
        issue(OP_LW, 0, 0, 8, 1'b0, 1'b0);
        issue(OP_R, 8, 3, 9, 1'b0, 1'b1);
        issue(OP_R, 8, 3, 9, 1'b0, 1'b0);

        repeat (3000) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 99) >= 30) begin
                D_op     = ops[$urandom_range(0, 8)];
                D_rs     = 5'($urandom_range(0, 7));
                D_rt     = 5'($urandom_range(0, 7));
                D_dst    = 5'($urandom_range(0, 7));
                D_valid  = ($urandom_range(0, 99) >= 10);
                D_wen    = (D_op == OP_R || D_op == OP_LW || D_op == OP_ADDI ||
                            D_op == OP_ORI || D_op == OP_JAL);
                D_isload = (D_op == OP_LW);
            end
            E_flush = ($urandom_range(0, 99) < 10);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
